// File: rtl/epd_tcon.sv
// EPD timing controller: frame/line sequencing of gate and source drivers, pixel word serialisation.
// Optional build macro EPD_UNDERRUN_FILL_EN: substitute a zero word on underrun instead of stalling.
module epd_tcon #(
  parameter int H_WORDS      = 50,
  parameter int V_LINES      = 1200,
  parameter int FRAME_SETUP  = 16,
  parameter int LE_CYCLES    = 4,
  parameter int GDCLK_CYCLES = 8,
  parameter int LINE_GAP     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        vsync,
  input  logic [63:0] pix_read,
  input  logic        pix_read_valid,
  output logic        pix_read_ready,
  output logic        epd_gdoe,
  output logic        epd_gdclk,
  output logic        epd_gdsp,
  output logic        epd_sdclk,
  output logic        epd_sdle,
  output logic        epd_sdoe,
  output logic [15:0] epd_sd,
  output logic        epd_sdce0,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int LW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int WW   = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int TM0  = (FRAME_SETUP > LE_CYCLES) ? FRAME_SETUP : LE_CYCLES;
  localparam int TM1  = (GDCLK_CYCLES > LINE_GAP) ? GDCLK_CYCLES : LINE_GAP;
  localparam int TMAX = (TM0 > TM1) ? TM0 : TM1;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_FSTART, S_DATA, S_LATCH, S_GATE, S_GAP, S_FEND} state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [LW-1:0]   line_r, line_s;
  logic [WW-1:0]   word_r, word_s;
  logic [1:0]      beat_r, beat_s;
  logic            ph_r, ph_s;
  logic            wait_r, wait_s;
  logic [63:0]     buf_r, buf_s;
  logic            vsync_s, gdoe_s, gdclk_s, gdsp_s, sdclk_s, sdle_s, sdoe_s, sdce0_s;
  logic            busy_s, done_s, underrun_s;
  logic [15:0]     sd_s;

  // Next-state, handshake and next-output decode; pins are the registered decode of the current state.
  always_comb begin
    state_s = state_r;  cnt_s = cnt_r;   line_s = line_r;  word_s = word_r;
    beat_s  = beat_r;   ph_s  = ph_r;    wait_s = wait_r;  buf_s  = buf_r;
    vsync_s = 1'b0;  gdoe_s = 1'b0;  gdclk_s = 1'b0;  gdsp_s = 1'b1;
    sdclk_s = 1'b0;  sdle_s = 1'b0;  sdoe_s  = 1'b0;  sdce0_s = 1'b1;
    busy_s  = 1'b1;  done_s = 1'b0;  underrun_s = underrun;  sd_s = epd_sd;
    pix_read_ready = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
        if (en) begin
          state_s = S_FSTART;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FSTART: begin
        vsync_s = (cnt_r == {CW{1'b0}});
        gdoe_s = 1'b1;  sdoe_s = 1'b1;  gdsp_s = 1'b0;  underrun_s = 1'b0;
        if (cnt_r == CW'(FRAME_SETUP - 1)) begin
          state_s = S_DATA;  cnt_s = {CW{1'b0}};  line_s = {LW{1'b0}};
          word_s = {WW{1'b0}};  beat_s = 2'd0;  ph_s = 1'b0;  wait_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_DATA: begin
        gdoe_s = 1'b1;  sdoe_s = 1'b1;  sdce0_s = 1'b0;
        gdsp_s = (line_r != {LW{1'b0}});
        if (wait_r) begin
          // Stalled at a word boundary: sdclk stays low and sd holds until a word arrives.
          pix_read_ready = 1'b1;
          if (pix_read_valid) begin
            buf_s  = pix_read;
            wait_s = 1'b0;
          end else begin
            wait_s = 1'b1;
          end
        end else if (!ph_r) begin
          if (word_r == {WW{1'b0}} && beat_r == 2'd0) begin
            // First cycle of the line: accepted word goes straight to the beat-0 register.
            pix_read_ready = 1'b1;
            if (pix_read_valid) begin
              buf_s = pix_read;  sd_s = pix_read[15:0];  ph_s = 1'b1;
            end else begin
              underrun_s = 1'b1;
`ifdef EPD_UNDERRUN_FILL_EN
              buf_s = 64'h0;  sd_s = 16'h0;  ph_s = 1'b1;
`else
              ph_s = 1'b0;
`endif
            end
          end else begin
            sd_s = buf_r[{beat_r, 4'd0} +: 16];
            ph_s = 1'b1;
          end
        end else begin
          sdclk_s = 1'b1;
          ph_s    = 1'b0;
          if (beat_r != 2'd3) begin
            beat_s = beat_r + 2'd1;
          end else if (word_r == WW'(H_WORDS - 1)) begin
            state_s = S_LATCH;  cnt_s = {CW{1'b0}};  beat_s = 2'd0;
          end else begin
            pix_read_ready = 1'b1;
            word_s = word_r + WW'(1);
            beat_s = 2'd0;
            if (pix_read_valid) begin
              buf_s = pix_read;
            end else begin
              underrun_s = 1'b1;
`ifdef EPD_UNDERRUN_FILL_EN
              buf_s = 64'h0;
`else
              wait_s = 1'b1;
`endif
            end
          end
        end
      end
      S_LATCH: begin
        gdoe_s = 1'b1;  sdoe_s = 1'b1;  sdle_s = 1'b1;
        gdsp_s = (line_r != {LW{1'b0}});
        if (cnt_r == CW'(LE_CYCLES - 1)) begin
          state_s = S_GATE;  cnt_s = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_GATE: begin
        gdoe_s = 1'b1;  sdoe_s = 1'b1;  gdclk_s = 1'b1;
        gdsp_s = (line_r != {LW{1'b0}});
        if (cnt_r == CW'(GDCLK_CYCLES - 1)) begin
          state_s = S_GAP;  cnt_s = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_GAP: begin
        gdoe_s = 1'b1;  sdoe_s = 1'b1;
        if (cnt_r != CW'(LINE_GAP - 1)) begin
          cnt_s = cnt_r + CW'(1);
        end else if (line_r == LW'(V_LINES - 1)) begin
          state_s = S_FEND;  cnt_s = {CW{1'b0}};
        end else begin
          state_s = S_DATA;  cnt_s = {CW{1'b0}};  line_s = line_r + LW'(1);
          word_s = {WW{1'b0}};  beat_s = 2'd0;  ph_s = 1'b0;  wait_s = 1'b0;
        end
      end
      S_FEND: begin
        done_s  = 1'b1;
        sd_s    = 16'h0;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State, counters, word buffer and registered driver outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;  cnt_r <= {CW{1'b0}};  line_r <= {LW{1'b0}};  word_r <= {WW{1'b0}};
      beat_r  <= 2'd0;    ph_r  <= 1'b0;        wait_r <= 1'b0;        buf_r  <= 64'h0;
      vsync <= 1'b0;  epd_gdoe <= 1'b0;  epd_gdclk <= 1'b0;  epd_gdsp <= 1'b1;
      epd_sdclk <= 1'b0;  epd_sdle <= 1'b0;  epd_sdoe <= 1'b0;  epd_sd <= 16'h0;
      epd_sdce0 <= 1'b1;  busy <= 1'b0;  frame_done <= 1'b0;  underrun <= 1'b0;
    end else begin
      state_r <= state_s;  cnt_r <= cnt_s;  line_r <= line_s;  word_r <= word_s;
      beat_r  <= beat_s;   ph_r  <= ph_s;   wait_r <= wait_s;  buf_r  <= buf_s;
      vsync <= vsync_s;  epd_gdoe <= gdoe_s;  epd_gdclk <= gdclk_s;  epd_gdsp <= gdsp_s;
      epd_sdclk <= sdclk_s;  epd_sdle <= sdle_s;  epd_sdoe <= sdoe_s;  epd_sd <= sd_s;
      epd_sdce0 <= sdce0_s;  busy <= busy_s;  frame_done <= done_s;  underrun <= underrun_s;
    end
  end

endmodule

// File: tb/tb_epd_tcon.sv
// Directed self-checking bench for epd_tcon with small frame parameters.
module tb_epd_tcon;
  logic clk = 1'b0, rst, en, pix_read_valid, pix_read_ready;
  logic [63:0] pix_read;
  logic vsync, epd_gdoe, epd_gdclk, epd_gdsp, epd_sdclk, epd_sdle, epd_sdoe, epd_sdce0;
  logic busy, frame_done, underrun;
  logic [15:0] epd_sd;

  epd_tcon #(.H_WORDS(2), .V_LINES(3), .FRAME_SETUP(5), .LE_CYCLES(2), .GDCLK_CYCLES(3), .LINE_GAP(4)) dut (
    .clk(clk), .rst(rst), .en(en), .vsync(vsync), .pix_read(pix_read),
    .pix_read_valid(pix_read_valid), .pix_read_ready(pix_read_ready),
    .epd_gdoe(epd_gdoe), .epd_gdclk(epd_gdclk), .epd_gdsp(epd_gdsp), .epd_sdclk(epd_sdclk),
    .epd_sdle(epd_sdle), .epd_sdoe(epd_sdoe), .epd_sd(epd_sd), .epd_sdce0(epd_sdce0),
    .busy(busy), .frame_done(frame_done), .underrun(underrun));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int vs_cnt, vs1, vs2, done_cnt, done1, done2, acc, pulses, gw_min, gw_max, grun;
  int gfall1, gsp_low1, gsp_rise1, unstable, nb, lowrun, lowmax;
  logic ur_done1, ur_vs2;
  logic [15:0] beats [0:63];

  function automatic logic [63:0] word_of(input int i);
    return {16'(4*i+4), 16'(4*i+3), 16'(4*i+2), 16'(4*i+1)};
  endfunction

  // Drives the pixel stream and records output events; n counts negedge samples.
  task automatic run(input int ncyc, input int en_off_at, input bit do_drop);
    logic p_gdclk = 1'b0, p_gdsp = 1'b1, p_sdclk = 1'b0;
    logic [15:0] p_sd = 16'h0;
    bit dropped = 1'b0, take;
    int left = 0;
    vs_cnt = 0; vs1 = -1; vs2 = -1; done_cnt = 0; done1 = -1; done2 = -1; acc = 0;
    pulses = 0; gw_min = 999; gw_max = 0; grun = 0; gfall1 = -1; gsp_low1 = -1; gsp_rise1 = -1;
    unstable = 0; nb = 0; lowrun = 0; lowmax = 0; ur_done1 = 1'b0; ur_vs2 = 1'b1;
    pix_read = word_of(0); pix_read_valid = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (left > 0) begin left--; if (left == 0) pix_read_valid = 1'b1; end
      if (do_drop && !dropped && pix_read_ready && acc == 1) begin
        dropped = 1'b1; pix_read_valid = 1'b0; left = 10;
      end
      take = pix_read_ready && pix_read_valid;
      if (vsync) begin
        if (vs_cnt == 0) vs1 = n;
        else if (vs_cnt == 1) begin vs2 = n; ur_vs2 = underrun; end
        vs_cnt++;
      end
      if (frame_done) begin
        if (done_cnt == 0) begin done1 = n; ur_done1 = underrun; end
        else if (done_cnt == 1) done2 = n;
        done_cnt++;
      end
      if (epd_gdclk && !p_gdclk) begin pulses++; grun = 1; end
      else if (epd_gdclk) grun++;
      if (!epd_gdclk && p_gdclk) begin
        if (grun < gw_min) gw_min = grun;
        if (grun > gw_max) gw_max = grun;
        if (gfall1 < 0) gfall1 = n;
      end
      if (!epd_gdsp && gsp_low1 < 0) gsp_low1 = n;
      if (epd_gdsp && !p_gdsp && gsp_rise1 < 0) gsp_rise1 = n;
      if (epd_sdclk && !p_sdclk) begin
        if (epd_sd !== p_sd) unstable++;
        if (nb < 64) beats[nb] = epd_sd;
        nb++;
      end
      if (!epd_sdce0 && !epd_sdclk) lowrun++; else lowrun = 0;
      if (lowrun > lowmax) lowmax = lowrun;
      p_gdclk = epd_gdclk; p_gdsp = epd_gdsp; p_sdclk = epd_sdclk; p_sd = epd_sd;
      if (n == en_off_at) en = 1'b0;
      @(posedge clk); #1;
      if (take) begin acc++; pix_read = word_of(acc); end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; en = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b1; en = 1'b0; pix_read_valid = 1'b0; pix_read = 64'h0;
    repeat (3) @(negedge clk);
    obs = {vsync, epd_gdoe, epd_gdclk, epd_gdsp, epd_sdclk, epd_sdle, epd_sdoe, epd_sdce0,
           busy, frame_done, underrun, pix_read_ready};
    n_cmp++; if (obs !== 12'b0001_0001_0000) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", obs, 12'b0001_0001_0000); end
    n_cmp++; if (epd_sd !== 16'h0) begin n_bad++; $display("FAIL reset_sd: got %h expected 0000", epd_sd); end
  endtask

  task automatic test_frame();
    do_reset();
    run(100, 50, 1'b0);
    n_cmp++; if (vs_cnt !== 1) begin n_bad++; $display("FAIL frame_vsync_count: got %0d expected 1", vs_cnt); end
    n_cmp++; if (done1 - vs1 !== 80) begin n_bad++; $display("FAIL frame_length: got %0d expected 80", done1 - vs1); end
    n_cmp++; if (acc !== 6) begin n_bad++; $display("FAIL frame_words: got %0d expected 6", acc); end
    n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL gdclk_pulses: got %0d expected 3", pulses); end
    n_cmp++; if (gw_min !== 3 || gw_max !== 3) begin n_bad++; $display("FAIL gdclk_width: got %0d..%0d expected 3", gw_min, gw_max); end
    n_cmp++; if (gsp_low1 !== vs1) begin n_bad++; $display("FAIL gdsp_fall: got %0d expected %0d", gsp_low1, vs1); end
    n_cmp++; if (gsp_rise1 !== gfall1 || gfall1 < 0) begin n_bad++; $display("FAIL gdsp_rise: got %0d expected %0d", gsp_rise1, gfall1); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL frame_underrun: got %b expected 0", underrun); end
    n_cmp++; if (nb !== 24) begin n_bad++; $display("FAIL sdclk_edges: got %0d expected 24", nb); end
    for (int k = 0; k < 24 && k < nb; k++) begin
      n_cmp++; if (beats[k] !== 16'(k+1)) begin n_bad++; $display("FAIL beat_%0d: got %h expected %h", k, beats[k], 16'(k+1)); end
    end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL sd_stability: got %0d unstable edges expected 0", unstable); end
    n_cmp++; if (lowmax !== 1) begin n_bad++; $display("FAIL sdclk_low_run: got %0d expected 1", lowmax); end
  endtask

  task automatic test_underrun();
    do_reset();
    run(115, 50, 1'b1);
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_flag: got %b expected 1", underrun); end
    n_cmp++; if (nb !== 24) begin n_bad++; $display("FAIL underrun_edges: got %0d expected 24", nb); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL underrun_stability: got %0d expected 0", unstable); end
`ifdef EPD_UNDERRUN_FILL_EN
    n_cmp++; if (done1 - vs1 !== 80) begin n_bad++; $display("FAIL fill_length: got %0d expected 80", done1 - vs1); end
    n_cmp++; if (acc !== 5) begin n_bad++; $display("FAIL fill_words: got %0d expected 5", acc); end
    n_cmp++; if (lowmax !== 1) begin n_bad++; $display("FAIL fill_low_run: got %0d expected 1", lowmax); end
    for (int k = 4; k < 8; k++) begin
      n_cmp++; if (beats[k] !== 16'h0) begin n_bad++; $display("FAIL fill_beat_%0d: got %h expected 0000", k, beats[k]); end
    end
`else
    n_cmp++; if (done1 - vs1 !== 90) begin n_bad++; $display("FAIL stall_length: got %0d expected 90", done1 - vs1); end
    n_cmp++; if (acc !== 6) begin n_bad++; $display("FAIL stall_words: got %0d expected 6", acc); end
    n_cmp++; if (lowmax !== 11) begin n_bad++; $display("FAIL stall_low_run: got %0d expected 11", lowmax); end
    for (int k = 4; k < 8; k++) begin
      n_cmp++; if (beats[k] !== 16'(k+1)) begin n_bad++; $display("FAIL stall_beat_%0d: got %h expected %h", k, beats[k], 16'(k+1)); end
    end
`endif
  endtask

  task automatic test_en_drop();
    do_reset();
    run(130, 40, 1'b0);
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL endrop_done_count: got %0d expected 1", done_cnt); end
    n_cmp++; if (done1 - vs1 !== 80) begin n_bad++; $display("FAIL endrop_length: got %0d expected 80", done1 - vs1); end
    n_cmp++; if (vs_cnt !== 1) begin n_bad++; $display("FAIL endrop_vsync_count: got %0d expected 1", vs_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL endrop_busy: got %b expected 0", busy); end
    n_cmp++; if (acc !== 6) begin n_bad++; $display("FAIL endrop_words: got %0d expected 6", acc); end
  endtask

  task automatic test_rst_gate();
    bit found = 1'b0;
    logic [4:0] obs;
    do_reset();
    pix_read = word_of(0); pix_read_valid = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (epd_gdclk) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rst_gate_reach: got no gdclk expected gdclk within 60 cycles"); end
    #2 rst = 1'b1;
    #1 obs = {epd_gdclk, epd_gdsp, epd_sdce0, epd_gdoe, busy};
    n_cmp++; if (obs !== 5'b01100) begin n_bad++; $display("FAIL rst_gate_outputs: got %b expected 01100", obs); end
    @(negedge clk); rst = 1'b0;
    run(6, -1, 1'b0);
    n_cmp++; if (vs_cnt !== 1) begin n_bad++; $display("FAIL rst_gate_vsync: got %0d expected 1", vs_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run(180, 100, 1'b1);
    n_cmp++; if (done_cnt !== 2 || vs_cnt !== 2) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d expected 2/2", done_cnt, vs_cnt); end
    n_cmp++; if (vs2 - done1 !== 2) begin n_bad++; $display("FAIL b2b_gap: got %0d expected 2", vs2 - done1); end
    n_cmp++; if (ur_done1 !== 1'b1) begin n_bad++; $display("FAIL b2b_underrun_set: got %b expected 1", ur_done1); end
    n_cmp++; if (ur_vs2 !== 1'b0) begin n_bad++; $display("FAIL b2b_underrun_clear: got %b expected 0", ur_vs2); end
    n_cmp++; if (done2 - vs2 !== 80) begin n_bad++; $display("FAIL b2b_second_length: got %0d expected 80", done2 - vs2); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pix_read_valid = 1'b0; pix_read = 64'h0;
    test_reset();
    test_frame();
    test_underrun();
    test_en_drop();
    test_rst_gate();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
